uart_link_buffer: RTL and testbench

//  Buffered, parametrised coupling block between UART receiver and transmitter.

---
 rtl/uart_link_buffer_pkg.sv | 28 ++
 rtl/uart_link_buffer_if.sv | 29 ++
 rtl/uart_link_buffer_link_fifo.sv | 76 +++++++
 rtl/uart_link_buffer.sv | 132 +++++++++++++
 tb/tb_uart_link_buffer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_link_buffer_pkg.sv
// Shared types for the UART link buffer: FSM states, transfer modes and
// the decoder from the raw 2-bit mode input.
package uart_link_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    REPEAT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    M_PASS   = 2'b00,
    M_SINK   = 2'b01,
    M_DOUBLE = 2'b10
  } mode_e;

  // Encoding 11 is treated as pass-through.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'b01:   m = M_SINK;
      2'b10:   m = M_DOUBLE;
      default: m = M_PASS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_link_buffer_if.sv
// Receiver/transmitter-side signal bundle of the link buffer. The master
// modport is the surrounding UART (or bench); the slave modport is the buffer.
interface uart_link_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              tx_done;
  logic [1:0]        mode;
  logic              rx_enable;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              busy;
  logic [LVL_W-1:0]  level;
  logic              overflow;

  modport master (
    output rx_valid, rx_data, tx_done, mode,
    input  rx_enable, tx_data, tx_start, busy, level, overflow
  );

  modport slave (
    input  rx_valid, rx_data, tx_done, mode,
    output rx_enable, tx_data, tx_start, busy, level, overflow
  );
endinterface

// File: rtl/uart_link_buffer_link_fifo.sv
// Synchronous FIFO with the head word visible combinationally (no read
// latency). A push on a full FIFO is only taken when a pop happens on the same edge.
module link_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clc,
  input  logic              res,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push_s;
  logic              do_pop_s;

  assign full      = (level_q == LVL_W'(DEPTH));
  assign empty     = (level_q == {LVL_W{1'b0}});
  assign head      = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Next pointer and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clc) begin
    if (!res) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care while empty, so it is not reset.
  always_ff @(posedge clc) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_link_buffer.sv
// Buffered coupling between UART receiver and transmitter: queues received
// words and hands them out with a start/done handshake in pass, sink or double-echo mode.
module uart_link_buffer
  import uart_link_buffer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 1
) (
  input logic               clc,
  input logic               res,
  uart_link_buffer_if.slave lnk
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] AF_LEVEL = LVL_W'(DEPTH - AF_MARGIN);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              rep_q, rep_d;
  logic              overflow_q, overflow_d;

  logic              push_req_s;
  logic              pop_s;
  logic [DATA_W-1:0] head_s;
  logic              full_s;
  logic              empty_s;
  logic [LVL_W-1:0]  level_s;

  link_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clc       (clc),
    .res       (res),
    .push      (push_req_s),
    .push_data (lnk.rx_data),
    .pop       (pop_s),
    .head      (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (level_s)
  );

  assign push_req_s = lnk.rx_valid & (decode_mode(lnk.mode) != M_SINK);
  assign pop_s      = (state_q == IDLE) & ~empty_s;

  // Overflow is sticky: a word is lost only when full and not popped this edge.
  always_comb begin
    overflow_d = overflow_q;
    if (push_req_s && full_s && !pop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Transfer FSM next-state: pop in IDLE, wait for done in BUSY, one gap cycle in REPEAT.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    rep_d      = rep_q;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          tx_data_d  = head_s;
          tx_start_d = 1'b1;
          mode_d     = decode_mode(lnk.mode);
          rep_d      = 1'b0;
          state_d    = BUSY;
        end else begin
          tx_start_d = 1'b0;
          state_d    = IDLE;
        end
      end
      BUSY: begin
        if (lnk.tx_done) begin
          tx_start_d = 1'b0;
          // The in-flight word follows the mode latched at its pop.
          if ((mode_q == M_DOUBLE) && !rep_q) begin
            state_d = REPEAT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tx_start_d = 1'b1;
          state_d    = BUSY;
        end
      end
      REPEAT: begin
        tx_start_d = 1'b1;
        rep_d      = 1'b1;
        state_d    = BUSY;
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // FSM and output registers with synchronous active-low reset.
  always_ff @(posedge clc) begin
    if (!res) begin
      state_q    <= IDLE;
      mode_q     <= M_PASS;
      tx_data_q  <= {DATA_W{1'b0}};
      tx_start_q <= 1'b0;
      rep_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rep_q      <= rep_d;
      overflow_q <= overflow_d;
    end
  end

  assign lnk.tx_data   = tx_data_q;
  assign lnk.tx_start  = tx_start_q;
  assign lnk.overflow  = overflow_q;
  assign lnk.level     = level_s;
  assign lnk.rx_enable = (level_s < AF_LEVEL);
  assign lnk.busy      = (state_q != IDLE) | ~empty_s;

endmodule

// File: tb/tb_uart_link_buffer.sv
// Self-checking bench for uart_link_buffer: directed vector table, hand-written
// full/reset sequences, and random traffic against a queue-based reference model.
module tb_uart_link_buffer;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 8;
  localparam int AF_MARGIN = 1;

  logic clc;
  logic res;

  uart_link_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) lnk ();

  uart_link_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AF_MARGIN)
  ) dut (
    .clc (clc),
    .res (res),
    .lnk (lnk)
  );

  initial clc = 1'b0;
  always #5 clc = ~clc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of pending words plus transmitter-side view.
  logic [7:0] q[$];
  bit         m_active;
  bit         m_gap;
  int         m_rem;
  logic [7:0] m_cur;
  bit         m_ovf;

  // Packed observation: {tx_start, tx_data[7:0], level[3:0], overflow, rx_enable, busy}
  function automatic logic [15:0] pack_out(input logic st, input logic [7:0] d,
                                           input logic [3:0] lv, input logic ov,
                                           input logic en, input logic bz);
    return {st, d, lv, ov, en, bz};
  endfunction

  function automatic logic [15:0] dut_out();
    return pack_out(lnk.tx_start, lnk.tx_data, lnk.level, lnk.overflow,
                    lnk.rx_enable, lnk.busy);
  endfunction

  function automatic logic [15:0] model_out();
    int sz;
    sz = q.size();
    return pack_out(m_active, m_cur, 4'(sz), m_ovf, (sz < DEPTH - AF_MARGIN),
                    m_active || m_gap || (sz > 0));
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [7:0] d,
                              input logic done, input logic [1:0] md);
    bit pop_now;
    bit push_req;
    if (!r) begin
      q.delete();
      m_active = 1'b0;
      m_gap    = 1'b0;
      m_rem    = 0;
      m_cur    = 8'h00;
      m_ovf    = 1'b0;
    end else begin
      pop_now  = !m_active && !m_gap && (q.size() > 0);
      push_req = v && (md != 2'b01);
      if (push_req && (q.size() == DEPTH) && !pop_now) m_ovf = 1'b1;
      if (m_active) begin
        if (done) begin
          m_active = 1'b0;
          if (m_rem > 0) begin
            m_rem--;
            m_gap = 1'b1;
          end
        end
      end else if (m_gap) begin
        m_gap    = 1'b0;
        m_active = 1'b1;
      end else if (pop_now) begin
        m_cur    = q.pop_front();
        m_active = 1'b1;
        m_rem    = (md == 2'b10) ? 1 : 0;
      end
      if (push_req && (q.size() < DEPTH)) q.push_back(d);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare 1 time unit later.
  task automatic step(input logic r, input logic v, input logic [7:0] d,
                      input logic done, input logic [1:0] md);
    res          = r;
    lnk.rx_valid = v;
    lnk.rx_data  = d;
    lnk.tx_done  = done;
    lnk.mode     = md;
    @(posedge clc);
    model_update(r, v, d, done, md);
    #1;
    chk("model", dut_out(), model_out());
  endtask

  typedef struct {
    logic        r;
    logic        v;
    logic [7:0]  d;
    logic        done;
    logic [1:0]  md;
    logic [15:0] exp;
  } vec_t;

  vec_t rows[24];

  initial begin
    res          = 1'b0;
    lnk.rx_valid = 1'b0;
    lnk.rx_data  = 8'h00;
    lnk.tx_done  = 1'b0;
    lnk.mode     = 2'b00;

    // Directed table: reset, single word, sink mode, in-order burst, double echo.
    rows[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0)};
    rows[1]  = '{1'b1, 1'b1, 8'h41, 1'b0, 2'b00, pack_out(1'b0, 8'h00, 4'd1, 1'b0, 1'b1, 1'b1)};
    rows[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b1, 8'h41, 4'd0, 1'b0, 1'b1, 1'b1)};
    rows[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b1, 8'h41, 4'd0, 1'b0, 1'b1, 1'b1)};
    rows[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, pack_out(1'b0, 8'h41, 4'd0, 1'b0, 1'b1, 1'b0)};
    rows[5]  = '{1'b1, 1'b1, 8'h11, 1'b0, 2'b01, pack_out(1'b0, 8'h41, 4'd0, 1'b0, 1'b1, 1'b0)};
    rows[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b01, pack_out(1'b0, 8'h41, 4'd0, 1'b0, 1'b1, 1'b0)};
    rows[7]  = '{1'b1, 1'b1, 8'h01, 1'b0, 2'b00, pack_out(1'b0, 8'h41, 4'd1, 1'b0, 1'b1, 1'b1)};
    rows[8]  = '{1'b1, 1'b1, 8'h02, 1'b0, 2'b00, pack_out(1'b1, 8'h01, 4'd1, 1'b0, 1'b1, 1'b1)};
    rows[9]  = '{1'b1, 1'b1, 8'h03, 1'b0, 2'b00, pack_out(1'b1, 8'h01, 4'd2, 1'b0, 1'b1, 1'b1)};
    rows[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b1, 8'h01, 4'd2, 1'b0, 1'b1, 1'b1)};
    rows[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, pack_out(1'b0, 8'h01, 4'd2, 1'b0, 1'b1, 1'b1)};
    rows[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b1, 8'h02, 4'd1, 1'b0, 1'b1, 1'b1)};
    rows[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, pack_out(1'b0, 8'h02, 4'd1, 1'b0, 1'b1, 1'b1)};
    rows[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b1, 8'h03, 4'd0, 1'b0, 1'b1, 1'b1)};
    rows[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, pack_out(1'b0, 8'h03, 4'd0, 1'b0, 1'b1, 1'b0)};
    rows[16] = '{1'b1, 1'b1, 8'h5A, 1'b0, 2'b10, pack_out(1'b0, 8'h03, 4'd1, 1'b0, 1'b1, 1'b1)};
    rows[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b10, pack_out(1'b1, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b1)};
    rows[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b1, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b1)};
    rows[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, pack_out(1'b0, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b1)};
    rows[20] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b1, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b1)};
    rows[21] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, pack_out(1'b0, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0)};
    rows[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b00, pack_out(1'b0, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0)};
    rows[23] = '{1'b1, 1'b0, 8'h00, 1'b1, 2'b00, pack_out(1'b0, 8'h5A, 4'd0, 1'b0, 1'b1, 1'b0)};

    for (int i = 0; i < 24; i++) begin
      step(rows[i].r, rows[i].v, rows[i].d, rows[i].done, rows[i].md);
      chk($sformatf("table_row%0d", i), dut_out(), rows[i].exp);
    end

    // Fill to full with the transmitter stalled, then overflow and push-at-pop.
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 8'h80 + 8'(i), 1'b0, 2'b00);
      if (i == 7) chk("rxen_low_at_7", 16'(lnk.rx_enable), 16'd0);
    end
    chk("full_level", 16'(lnk.level), 16'd8);
    chk("full_rxen", 16'(lnk.rx_enable), 16'd0);
    step(1'b1, 1'b1, 8'hEE, 1'b0, 2'b00);
    chk("ovf_set", {15'd0, lnk.overflow}, 16'd1);
    chk("ovf_level", 16'(lnk.level), 16'd8);
    step(1'b1, 1'b0, 8'h00, 1'b1, 2'b00);
    step(1'b1, 1'b1, 8'h99, 1'b0, 2'b00);
    chk("push_at_pop_level", 16'(lnk.level), 16'd8);
    chk("push_at_pop_data", 16'(lnk.tx_data), 16'h0081);
    begin
      int guard;
      guard = 0;
      while ((lnk.busy || lnk.level != 0) && guard < 200) begin
        step(1'b1, 1'b0, 8'h00, m_active, 2'b00);
        guard++;
      end
      chk("drain_bounded", 16'(guard < 200), 16'd1);
    end
    chk("ovf_sticky", {15'd0, lnk.overflow}, 16'd1);

    // Reset in the middle of a transfer with words queued and overflow set.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0, 2'b00);
    chk("pre_reset_busy", {lnk.tx_start, 11'd0, lnk.level}, {1'b1, 11'd0, 4'd3});
    step(1'b0, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("mid_reset", dut_out(), pack_out(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0));
    step(1'b1, 1'b0, 8'h00, 1'b1, 2'b00);
    chk("stray_done", dut_out(), pack_out(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0));

    // Random traffic against the model.
    begin
      logic [1:0] md;
      md = 2'b00;
      for (int i = 0; i < 3000; i++) begin
        logic r, v, dn;
        if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
        r  = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
        v  = ($urandom_range(0, 9) < 4);
        dn = m_active ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
        step(r, v, 8'($urandom), dn, md);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
